button_conditioner: RTL and testbench

//   Conditions a raw, asynchronous push-button for the counter stage downstream.

---
 rtl/button_conditioner_pkg.sv | 23 ++
 rtl/button_conditioner_sync_chain.sv | 23 ++
 rtl/button_conditioner.sv | 113 +++++++++++
 tb/tb_button_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types for the push-button conditioner: debounce FSM encoding and default constants.
package button_conditioner_pkg;

  // Bit 0 set means "qualifying a change"; bit 1 mirrors the accepted level.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    QUAL_HI   = 2'b01,
    STABLE_HI = 2'b10,
    QUAL_LO   = 2'b11
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  function automatic logic is_qual(input state_t s);
    return (s == QUAL_HI) || (s == QUAL_LO);
  endfunction

  function automatic state_t stable_of(input logic level);
    return level ? STABLE_HI : STABLE_LO;
  endfunction

endpackage

// File: rtl/button_conditioner_sync_chain.sv
// Multi-flop synchroniser for the asynchronous button pad; kept separate so CDC cells stay isolated.
module button_conditioner_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce, detect edges and maintain a press-toggle level
// that drives the counter select input.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit TOGGLE_INIT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic toggle,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s_in;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             level_d, rise_d, fall_d, toggle_d, busy_d;

  button_conditioner_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (s_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
      toggle    <= TOGGLE_INIT;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_level <= level_d;
      btn_rise  <= rise_d;
      btn_fall  <= fall_d;
      toggle    <= toggle_d;
      busy      <= busy_d;
    end
  end

  // cnt holds the number of consecutive mismatching samples already seen, so the
  // edge that sees the DEBOUNCE_CYCLES-th mismatch accepts; cnt never passes CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (!ena) begin
      state_d = stable_of(btn_level);
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        STABLE_LO, QUAL_HI: begin
          if (!s_in) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            accept  = 1'b1;
          end else begin
            state_d = QUAL_HI;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        STABLE_HI, QUAL_LO: begin
          if (s_in) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            accept  = 1'b1;
          end else begin
            state_d = QUAL_LO;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = stable_of(btn_level);
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pulses and toggle are registered on the same edge that flips btn_level.
  always_comb begin
    level_d  = btn_level ^ accept;
    rise_d   = accept & ~btn_level;
    fall_d   = accept & btn_level;
    toggle_d = toggle ^ rise_d;
    busy_d   = is_qual(state_d);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: fixed vector table, directed corner sequences,
// then randomized stimulus compared against a run-length debounce model.
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_level, btn_rise, btn_fall, toggle, busy;

  button_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .TOGGLE_INIT     (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .toggle    (toggle),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_rise = 0;
  int n_fall = 0;

  // Reference model: raw samples delayed through a queue, then a run length of
  // consecutive enabled mismatches; a run of DEB flips the level.
  bit m_hist[$];
  bit m_level, m_rise, m_fall, m_tog, m_busy;
  int m_run;

  typedef struct {
    bit rst_n, ena, raw;
    bit lvl, rise, fall, tog, busy;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit r_n, input bit e, input bit r, input bit lvl,
                              input bit rise, input bit fall, input bit tog, input bit bsy);
    vec_t v;
    v.rst_n = r_n; v.ena = e; v.raw = r;
    v.lvl = lvl; v.rise = rise; v.fall = fall; v.tog = tog; v.busy = bsy;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    m_tog = 1'b0; m_busy = 1'b0; m_run = 0;
  endtask

  task automatic model_edge(input bit e, input bit r);
    bit s;
    s = m_hist.pop_front();
    m_hist.push_back(r);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!e || s == m_level) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DEB) begin
        m_level = !m_level;
        m_run = 0;
        if (m_level) begin
          m_rise = 1'b1;
          m_tog = !m_tog;
        end else begin
          m_fall = 1'b1;
        end
      end
    end
    m_busy = (m_run > 0);
  endtask

  // Inputs change right after a falling edge; outputs are sampled on the next falling edge.
  task automatic step(input bit r_n, input bit e, input bit r);
    rst_n = r_n; ena = e; btn_raw = r;
    if (!r_n) model_reset();
    @(posedge clk);
    if (r_n) model_edge(e, r);
    @(negedge clk);
    if (btn_rise) n_rise++;
    if (btn_fall) n_fall++;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".level"}, btn_level, m_level);
    check({tag, ".rise"}, btn_rise, m_rise);
    check({tag, ".fall"}, btn_fall, m_fall);
    check({tag, ".toggle"}, toggle, m_tog);
    check({tag, ".busy"}, busy, m_busy);
    check({tag, ".excl"}, btn_rise & btn_fall, 1'b0);
  endtask

  task automatic run(input bit r, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, r);
      check_model($sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit raw_r, ena_r;
    int hold;
    model_reset();

    // ---- vector table: reset, first press, release, bounce ----
    add(0,1,1, 0,0,0,0,0);
    add(0,1,1, 0,0,0,0,0);
    add(1,1,1, 0,0,0,0,0);
    add(1,1,1, 0,0,0,0,0);
    add(1,1,1, 0,0,0,0,1);
    add(1,1,1, 0,0,0,0,1);
    add(1,1,1, 0,0,0,0,1);
    add(1,1,1, 1,1,0,1,0);
    add(1,1,1, 1,0,0,1,0);
    add(1,1,1, 1,0,0,1,0);
    add(1,1,0, 1,0,0,1,0);
    add(1,1,0, 1,0,0,1,0);
    add(1,1,0, 1,0,0,1,1);
    add(1,1,0, 1,0,0,1,1);
    add(1,1,0, 1,0,0,1,1);
    add(1,1,0, 0,0,1,1,0);
    add(1,1,0, 0,0,0,1,0);
    add(1,1,0, 0,0,0,1,0);
    add(1,1,1, 0,0,0,1,0);
    add(1,1,1, 0,0,0,1,0);
    add(1,1,1, 0,0,0,1,1);
    add(1,1,0, 0,0,0,1,1);
    add(1,1,1, 0,0,0,1,1);
    add(1,1,1, 0,0,0,1,0);
    add(1,1,1, 0,0,0,1,1);
    add(1,1,1, 0,0,0,1,1);
    add(1,1,1, 0,0,0,1,1);
    add(1,1,1, 1,1,0,0,0);
    add(1,1,1, 1,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].ena, vecs[i].raw);
      check($sformatf("vec%0d.level", i), btn_level, vecs[i].lvl);
      check($sformatf("vec%0d.rise", i), btn_rise, vecs[i].rise);
      check($sformatf("vec%0d.fall", i), btn_fall, vecs[i].fall);
      check($sformatf("vec%0d.toggle", i), toggle, vecs[i].tog);
      check($sformatf("vec%0d.busy", i), busy, vecs[i].busy);
    end

    // ---- two clean presses: toggle 0->1->0, two rises and two falls ----
    run(1'b0, 8, "rel0");
    n_rise = 0;
    n_fall = 0;
    run(1'b1, 8, "press1");
    check("press1.toggle", toggle, 1'b1);
    run(1'b0, 8, "rel1");
    run(1'b1, 8, "press2");
    check("press2.toggle", toggle, 1'b0);
    run(1'b0, 8, "rel2");
    check_int("two_press.rises", n_rise, 2);
    check_int("two_press.falls", n_fall, 2);

    // ---- ena dropped mid-qualification, then re-qualified from zero ----
    run(1'b1, 4, "qual");
    check("qual.busy", busy, 1'b1);
    n_rise = 0;
    step(1'b1, 1'b0, 1'b1);
    check_model("ena_off");
    check("ena_off.busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      check_model($sformatf("ena_hold[%0d]", i));
    end
    check("ena_hold.level", btn_level, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check_model($sformatf("ena_on[%0d]", i));
      check($sformatf("ena_on[%0d].level", i), btn_level, (i == 4));
    end
    check_int("ena_on.rises", n_rise, 1);

    // ---- asynchronous reset in the middle of a release qualification ----
    run(1'b1, 2, "pre_rst");
    run(1'b0, 4, "rst_qual");
    check("rst_qual.busy", busy, 1'b1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst.level", btn_level, 1'b0);
    check("async_rst.busy", busy, 1'b0);
    check("async_rst.toggle", toggle, 1'b0);
    check("async_rst.rise", btn_rise, 1'b0);
    check("async_rst.fall", btn_fall, 1'b0);
    @(negedge clk);
    step(1'b0, 1'b1, 1'b0);
    n_rise = 0;
    n_fall = 0;
    run(1'b0, 10, "post_rst");
    check_int("post_rst.pulses", n_rise + n_fall, 0);

    // ---- randomized stimulus against the model ----
    hold = 0;
    raw_r = 1'b0;
    ena_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        raw_r = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      if ($urandom_range(0, 24) == 0) ena_r = !ena_r;
      if ($urandom_range(0, 199) == 0) step(1'b0, ena_r, raw_r);
      else step(1'b1, ena_r, raw_r);
      check_model($sformatf("rnd[%0d]", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
